// File: rtl/fcvt_seq_if.sv
// Request/result handshake bundle for the fcvt_seq float<->int converter.
// The unit side uses the slave modport; the requester/writeback side uses master.
interface fcvt_seq_if;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  op;
   logic [31:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic        out_nv;
   logic        out_nx;

   modport master (
      output in_valid, op, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_nv, out_nx
   );

   modport slave (
      input  in_valid, op, in_data, out_ready,
      output in_ready, out_valid, out_data, out_nv, out_nx
   );
endinterface

// File: rtl/fcvt_seq.sv
// Multi-cycle FCVT.W.S / WU.S / S.W / S.WU converter for the FP execute stage.
// One request in flight; the result is held in DONE until writeback accepts it.
module fcvt_seq (
   input  logic      clk,
   input  logic      rst,
   fcvt_seq_if.slave bus,
   output logic      busy
);

   typedef enum logic [2:0] {S_IDLE, S_UNPACK, S_SHIFT, S_ROUND, S_DONE} state_t;
   state_t state, state_nx;

   logic [1:0]  op_r;
   logic [31:0] d_r;
   logic        sgn_r, zero_r, nan_r, den_r;
   logic [31:0] mag_r, norm_r, ival_r;
   logic [4:0]  msb_r;
   logic        stk_r;
   logic [31:0] data_q;
   logic        nv_q, nx_q;

   logic        sgn_c, zero_c, nan_c, den_c;
   logic [31:0] mag_c, norm_c, ival_c, m32;
   logic [4:0]  msb_c, sh_c;
   logic        stk_c;
   logic [7:0]  ex;
   logic        guard, rsticky;
   logic [24:0] sum;
   logic [7:0]  exp_c;
   logic [31:0] res_c;
   logic        nv_c, nx_c;
   logic        accept;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx     = state;
      bus.in_ready = 1'b0;
      bus.out_valid = 1'b0;
      busy         = 1'b1;
      case (state)
         S_IDLE: begin
            bus.in_ready = ~rst;
            busy         = 1'b0;
            if (bus.in_valid && !rst) state_nx = S_UNPACK;
         end
         S_UNPACK: state_nx = S_SHIFT;
         S_SHIFT:  state_nx = S_ROUND;
         S_ROUND:  state_nx = S_DONE;
         S_DONE: begin
            bus.out_valid = 1'b1;
            if (bus.out_ready) state_nx = S_IDLE;
         end
         default:  state_nx = S_IDLE;
      endcase
   end

   assign accept = bus.in_valid & bus.in_ready;
   assign ex     = d_r[30:23];
   assign m32    = {1'b1, d_r[22:0], 8'h00};

   always_comb begin
      sgn_c  = op_r[1] ? (~op_r[0] & d_r[31]) : d_r[31];
      mag_c  = (op_r == 2'b10 && d_r[31]) ? (~d_r + 32'd1) : d_r;
      zero_c = op_r[1] ? (d_r == '0) : (d_r[30:0] == '0);
      nan_c  = (ex == 8'hFF) && (d_r[22:0] != '0);
      den_c  = (ex == 8'h00);
   end

   // msb_c doubles as the leading-zero count: lzc = 31 - msb_c.
   always_comb begin
      msb_c = '0;
      for (int unsigned i = 0; i < 32; i++)
         if (mag_r[i]) msb_c = i[4:0];
      norm_c = mag_r << (5'd31 - msb_c);
      sh_c   = 5'(8'd158 - ex);
      ival_c = '0;
      stk_c  = 1'b0;
      if (ex < 8'd127)
         stk_c = ~zero_r;
      else if (ex <= 8'd158) begin
         ival_c = m32 >> sh_c;
         stk_c  = |(m32 & ~(32'hFFFF_FFFF << sh_c));
      end
   end

   always_comb begin
      guard   = norm_r[7];
      rsticky = |norm_r[6:0];
      sum     = {1'b0, norm_r[31:8]} + {24'b0, guard & (rsticky | norm_r[8])};
      exp_c   = 8'd127 + {3'b0, msb_r} + {7'b0, sum[24]};
      res_c   = '0;
      nv_c    = 1'b0;
      nx_c    = 1'b0;
      if (op_r[1]) begin
         if (!zero_r) begin
            // On mantissa carry-out sum is 2^24, so sum[23:1] is the all-zero fraction.
            res_c = {sgn_r, exp_c, sum[24] ? sum[23:1] : sum[22:0]};
            nx_c  = guard | rsticky;
         end
      end else if (den_r) begin
         nx_c = (d_r[22:0] != '0);
      end else if (nan_r) begin
         res_c = op_r[0] ? 32'hFFFF_FFFF : 32'h7FFF_FFFF;
         nv_c  = 1'b1;
      end else if (!op_r[0]) begin
         if (ex >= 8'd158) begin
            if (!sgn_r) begin
               res_c = 32'h7FFF_FFFF;
               nv_c  = 1'b1;
            end else begin
               res_c = 32'h8000_0000;
               nv_c  = (d_r != 32'hCF00_0000);
            end
         end else begin
            res_c = sgn_r ? (~ival_r + 32'd1) : ival_r;
            nx_c  = stk_r;
         end
      end else begin
         if (sgn_r) begin
            if (ex >= 8'd127) nv_c = 1'b1;
            else              nx_c = 1'b1;
         end else if (ex >= 8'd159) begin
            res_c = 32'hFFFF_FFFF;
            nv_c  = 1'b1;
         end else begin
            res_c = ival_r;
            nx_c  = stk_r;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_r <= '0; d_r <= '0;
         sgn_r <= 1'b0; zero_r <= 1'b0; nan_r <= 1'b0; den_r <= 1'b0;
         mag_r <= '0; norm_r <= '0; ival_r <= '0; msb_r <= '0; stk_r <= 1'b0;
         data_q <= '0; nv_q <= 1'b0; nx_q <= 1'b0;
      end else begin
         case (state)
            S_IDLE: if (accept) begin
               op_r <= bus.op;
               d_r  <= bus.in_data;
            end
            S_UNPACK: begin
               sgn_r <= sgn_c; mag_r <= mag_c; zero_r <= zero_c;
               nan_r <= nan_c; den_r <= den_c;
            end
            S_SHIFT: begin
               msb_r <= msb_c; norm_r <= norm_c; ival_r <= ival_c; stk_r <= stk_c;
            end
            S_ROUND: begin
               data_q <= res_c; nv_q <= nv_c; nx_q <= nx_c;
            end
            default: ;
         endcase
      end
   end

   assign bus.out_data = data_q;
   assign bus.out_nv   = nv_q;
   assign bus.out_nx   = nx_q;

endmodule

// File: tb/tb_fcvt_seq.sv
// Directed bench for fcvt_seq: value-level reference model, per-cycle result
// checker, handshake timing, backpressure and mid-operation reset.
module tb_fcvt_seq;

   logic clk;
   logic rst;
   logic busy;

   fcvt_seq_if bus();

   fcvt_seq u_dut (
      .clk  (clk),
      .rst  (rst),
      .bus  (bus),
      .busy (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] r;
      logic        nv;
      logic        nx;
   } exp_t;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] d;
      logic [31:0] r;
      logic        nv;
      logic        nx;
   } vec_t;

   exp_t exp_q[$];
   vec_t vecs[$];
   int   checks = 0;
   int   passes = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got === want) passes++;
      else $display("FAIL %s: got %h expected %h", name, got, want);
   endtask

   function automatic real pow2(input int k);
      real p;
      p = 1.0;
      if (k >= 0) repeat (k) p = p * 2.0;
      else        repeat (-k) p = p / 2.0;
      return p;
   endfunction

   // Value-level reference: decode to a number, convert, then apply rounding/saturation rules.
   function automatic void model(input logic [1:0] o, input logic [31:0] d,
                                 output logic [31:0] r, output logic nv, output logic nx);
      longint a, q, n, rem, half, ti;
      int     k;
      logic   s;
      logic [7:0]  e;
      logic [22:0] f;
      real    av, t, fr;
      r = '0; nv = 1'b0; nx = 1'b0;
      if (o[1]) begin
         s = (o == 2'b10) && d[31];
         a = {32'h0, d};
         if (s) a = 64'h1_0000_0000 - a;
         if (a == 0) return;
         k = 0;
         while ((64'd1 << (k + 1)) <= a) k++;
         rem = 0;
         if (k <= 23) n = a << (23 - k);
         else begin
            q    = 64'd1 << (k - 23);
            n    = a / q;
            rem  = a % q;
            half = q / 2;
            if (rem > half || (rem == half && n[0])) n++;
         end
         nx = (rem != 0);
         if (n == (64'd1 << 24)) begin
            n = n >> 1;
            k++;
         end
         r = {s, 8'(k + 127), n[22:0]};
      end else begin
         s = d[31]; e = d[30:23]; f = d[22:0];
         if (e == 8'hFF && f != 0) begin
            r = o[0] ? 32'hFFFF_FFFF : 32'h7FFF_FFFF;
            nv = 1'b1;
            return;
         end
         if (e == 8'h00) begin
            nx = (f != 0);
            return;
         end
         fr = f;
         if (e == 8'hFF) av = 1.0e300;
         else            av = (1.0 + fr / 8388608.0) * pow2(int'(e) - 127);
         t = $floor(av);
         if (!o[0]) begin
            if (!s && t > 2147483647.0) begin r = 32'h7FFF_FFFF; nv = 1'b1; end
            else if (s && t > 2147483648.0) begin r = 32'h8000_0000; nv = 1'b1; end
            else begin
               ti = longint'(t);
               r  = s ? 32'(-ti) : 32'(ti);
               nx = (av != t);
            end
         end else begin
            if (s) begin
               if (t >= 1.0) nv = 1'b1;
               else          nx = 1'b1;
            end else if (t > 4294967295.0) begin
               r = 32'hFFFF_FFFF; nv = 1'b1;
            end else begin
               r  = 32'(longint'(t));
               nx = (av != t);
            end
         end
      end
   endfunction

   // Every cycle a result is presented it must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (!rst && bus.out_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_result", 32'd1, 32'd0);
         end else begin
            chk("out_data", bus.out_data, exp_q[0].r);
            chk("out_nv", {31'b0, bus.out_nv}, {31'b0, exp_q[0].nv});
            chk("out_nx", {31'b0, bus.out_nx}, {31'b0, exp_q[0].nx});
            if (bus.out_ready === 1'b1) void'(exp_q.pop_front());
         end
      end
   end

   // Called at posedge+1; returns at posedge+1 just after the accepting edge.
   task automatic issue(input logic [1:0] o, input logic [31:0] d);
      int   n;
      exp_t e;
      n = 0;
      while (bus.in_ready !== 1'b1 && n < 40) begin
         @(posedge clk); #1; n++;
      end
      chk("issue_in_ready", {31'b0, bus.in_ready}, 32'd1);
      bus.in_valid = 1'b1;
      bus.op       = o;
      bus.in_data  = d;
      model(o, d, e.r, e.nv, e.nx);
      exp_q.push_back(e);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 60) begin
         @(posedge clk); #1; n++;
      end
      chk("drain_pending", exp_q.size(), 32'd0);
   endtask

   task automatic addv(input logic [1:0] o, input logic [31:0] d, input logic [31:0] r,
                       input logic nv, input logic nx);
      vec_t v;
      v.op = o; v.d = d; v.r = r; v.nv = nv; v.nx = nx;
      vecs.push_back(v);
   endtask

   initial begin
      logic [31:0] mr;
      logic        mnv, mnx;
      int          n;

      rst = 1'b1;
      bus.in_valid = 1'b0; bus.op = '0; bus.in_data = '0; bus.out_ready = 1'b1;
      #2;
      chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
      chk("rst_out_data", bus.out_data, 32'd0);
      chk("rst_out_nv", {31'b0, bus.out_nv}, 32'd0);
      chk("rst_out_nx", {31'b0, bus.out_nx}, 32'd0);
      chk("rst_busy", {31'b0, busy}, 32'd0);
      #10 rst = 1'b0;
      @(posedge clk); #1;
      chk("post_rst_in_ready", {31'b0, bus.in_ready}, 32'd1);

      // Latency: accept edge counts as the first of four; DONE is seen after the third edge that follows.
      issue(2'b10, 32'h0000_0007);
      chk("lat_busy_unpack", {31'b0, busy}, 32'd1);
      chk("lat_in_ready_busy", {31'b0, bus.in_ready}, 32'd0);
      for (int i = 1; i <= 3; i++) begin
         @(posedge clk); #1;
         chk($sformatf("lat_busy_%0d", i), {31'b0, busy}, 32'd1);
         chk($sformatf("lat_out_valid_%0d", i), {31'b0, bus.out_valid}, (i == 3) ? 32'd1 : 32'd0);
      end
      chk("sw7_data_direct", bus.out_data, 32'h40E0_0000);
      @(posedge clk); #1;
      chk("done_to_idle_valid", {31'b0, bus.out_valid}, 32'd0);
      chk("done_to_idle_busy", {31'b0, busy}, 32'd0);
      chk("done_to_idle_ready", {31'b0, bus.in_ready}, 32'd1);

      addv(2'b10, 32'h0000_0007, 32'h40E0_0000, 1'b0, 1'b0);
      addv(2'b10, 32'h0100_0001, 32'h4B80_0000, 1'b0, 1'b1);
      addv(2'b10, 32'h0100_0003, 32'h4B80_0002, 1'b0, 1'b1);
      addv(2'b10, 32'h8000_0000, 32'hCF00_0000, 1'b0, 1'b0);
      addv(2'b10, 32'hFFFF_FFFF, 32'hBF80_0000, 1'b0, 1'b0);
      addv(2'b10, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0);
      addv(2'b11, 32'hFFFF_FFFF, 32'h4F80_0000, 1'b0, 1'b1);
      addv(2'b11, 32'h0000_0001, 32'h3F80_0000, 1'b0, 1'b0);
      addv(2'b00, 32'hC070_0000, 32'hFFFF_FFFD, 1'b0, 1'b1);
      addv(2'b00, 32'h4F00_0000, 32'h7FFF_FFFF, 1'b1, 1'b0);
      addv(2'b00, 32'hCF00_0000, 32'h8000_0000, 1'b0, 1'b0);
      addv(2'b00, 32'h7FC0_0000, 32'h7FFF_FFFF, 1'b1, 1'b0);
      addv(2'b00, 32'hFF80_0000, 32'h8000_0000, 1'b1, 1'b0);
      addv(2'b00, 32'h3F00_0000, 32'h0000_0000, 1'b0, 1'b1);
      addv(2'b00, 32'h8000_0000, 32'h0000_0000, 1'b0, 1'b0);
      addv(2'b01, 32'hBF00_0000, 32'h0000_0000, 1'b0, 1'b1);
      addv(2'b01, 32'hC000_0000, 32'h0000_0000, 1'b1, 1'b0);
      addv(2'b01, 32'h4F80_0000, 32'hFFFF_FFFF, 1'b1, 1'b0);
      addv(2'b01, 32'h0000_0001, 32'h0000_0000, 1'b0, 1'b1);
      addv(2'b01, 32'h4F7F_FFFF, 32'hFFFF_FF00, 1'b0, 1'b0);

      foreach (vecs[i]) begin
         model(vecs[i].op, vecs[i].d, mr, mnv, mnx);
         chk($sformatf("model_data op%0d %h", vecs[i].op, vecs[i].d), mr, vecs[i].r);
         chk($sformatf("model_nv op%0d %h", vecs[i].op, vecs[i].d), {31'b0, mnv}, {31'b0, vecs[i].nv});
         chk($sformatf("model_nx op%0d %h", vecs[i].op, vecs[i].d), {31'b0, mnx}, {31'b0, vecs[i].nx});
         issue(vecs[i].op, vecs[i].d);
      end
      drain();

      // Backpressure: result must hold while new requests are offered and refused.
      bus.out_ready = 1'b0;
      issue(2'b00, 32'hC070_0000);
      n = 0;
      while (bus.out_valid !== 1'b1 && n < 20) begin
         @(posedge clk); #1; n++;
      end
      chk("bp_out_valid", {31'b0, bus.out_valid}, 32'd1);
      for (int i = 0; i < 3; i++) begin
         bus.in_valid = 1'b1;
         bus.op       = 2'b10;
         bus.in_data  = 32'h1234_5678 + 32'(i);
         @(posedge clk); #1;
         chk("bp_in_ready", {31'b0, bus.in_ready}, 32'd0);
         chk("bp_valid_held", {31'b0, bus.out_valid}, 32'd1);
         chk("bp_data_held", bus.out_data, 32'hFFFF_FFFD);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp_release_valid", {31'b0, bus.out_valid}, 32'd0);
      chk("bp_release_busy", {31'b0, busy}, 32'd0);
      chk("bp_release_ready", {31'b0, bus.in_ready}, 32'd1);
      @(posedge clk); #1;
      chk("bp_not_accepted", {31'b0, busy}, 32'd0);
      chk("bp_queue_empty", exp_q.size(), 32'd0);
      issue(2'b11, 32'h0000_0001);
      drain();

      // Mid-operation reset during SHIFT of a W.S op; previous result (1.0f) is still on the outputs.
      issue(2'b00, 32'hC070_0000);
      @(posedge clk); #2;
      rst = 1'b1;
      exp_q.delete();
      #1;
      chk("mid_rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
      chk("mid_rst_out_data", bus.out_data, 32'd0);
      chk("mid_rst_out_nv", {31'b0, bus.out_nv}, 32'd0);
      chk("mid_rst_out_nx", {31'b0, bus.out_nx}, 32'd0);
      chk("mid_rst_busy", {31'b0, busy}, 32'd0);
      #3 rst = 1'b0;
      #1;
      chk("mid_rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
      @(posedge clk); #1;
      issue(2'b10, 32'h0000_0007);
      drain();
      chk("after_rst_sw7", bus.out_data, 32'h40E0_0000);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

endmodule
